// File: rtl/uart_packet_parser.sv
// Framed command packet parser fed by a UART receiver byte stream.
// Frame: 0xA5, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN and payload).
// A validated packet is held until pkt_ack; payload is read through rd_addr/rd_data.
module uart_packet_parser #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1000,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1),
  localparam int unsigned ADDR_W = $clog2(MAX_LEN),
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data,
  input  logic              new_data,
  output logic              pkt_valid,
  output logic [7:0]        pkt_cmd,
  output logic [LEN_W-1:0]  pkt_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              pkt_ack,
  output logic              busy,
  output logic              pkt_err,
  output logic [1:0]        err_code
);

  localparam logic [7:0]      SyncByte = 8'hA5;
  localparam logic [7:0]      MaxLenB  = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] ToLast   = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ErrOverrun  = 2'b00;
  localparam logic [1:0] ErrLength   = 2'b01;
  localparam logic [1:0] ErrChecksum = 2'b10;
  localparam logic [1:0] ErrTimeout  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StLen,
    StPayload,
    StChk,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_q [MAX_LEN];

  logic              timeout_hit;
  logic              last_payload;

  // Next-state, datapath updates and error generation.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    len_d        = len_q;
    xor_d        = xor_q;
    idx_d        = idx_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    buf_we       = 1'b0;
    buf_waddr    = idx_q;
    last_payload = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    // A byte on the expiry cycle wins over the timeout.
    timeout_hit  = busy_q && !new_data && (to_cnt_q == ToLast);

    unique case (state_q)
      StIdle: begin
        if (new_data && (data == SyncByte)) begin
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (new_data) begin
          cmd_d   = data;
          xor_d   = data;
          state_d = StLen;
        end
      end
      StLen: begin
        if (new_data) begin
          if (data > MaxLenB) begin
            err_d      = 1'b1;
            err_code_d = ErrLength;
            state_d    = StIdle;
          end else begin
            len_d   = LEN_W'(data);
            xor_d   = xor_q ^ data;
            idx_d   = '0;
            state_d = (data == 8'h00) ? StChk : StPayload;
          end
        end
      end
      StPayload: begin
        if (new_data) begin
          buf_we = 1'b1;
          xor_d  = xor_q ^ data;
          idx_d  = idx_q + ADDR_W'(1);
          if (last_payload) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (new_data) begin
          if (data == xor_q) begin
            state_d = StHold;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrChecksum;
            state_d    = StIdle;
          end
        end
      end
      StHold: begin
        if (pkt_ack) begin
          // Ack releases the packet; a simultaneous byte is treated as an idle byte.
          state_d = (new_data && (data == SyncByte)) ? StCmd : StIdle;
        end else if (new_data) begin
          err_d      = 1'b1;
          err_code_d = ErrOverrun;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout_hit) begin
      err_d      = 1'b1;
      err_code_d = ErrTimeout;
      state_d    = StIdle;
    end

    busy_d  = (state_d == StCmd) || (state_d == StLen) ||
              (state_d == StPayload) || (state_d == StChk);
    valid_d = (state_d == StHold);

    // Gap counter restarts on every byte and idles at zero outside a frame.
    if (new_data || !busy_d) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Control and packet-header registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= 8'h00;
      len_q      <= '0;
      xor_q      <= 8'h00;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrOverrun;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  // Payload buffer; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_waddr] <= data;
    end
  end

  assign rd_data   = buf_q[rd_addr];
  assign pkt_valid = valid_q;
  assign pkt_cmd   = cmd_q;
  assign pkt_len   = len_q;
  assign busy      = busy_q;
  assign pkt_err   = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed self-checking bench for uart_packet_parser (MAX_LEN 16, TIMEOUT 1000).
module tb_uart_packet_parser;

  localparam int unsigned MaxLen  = 16;
  localparam int unsigned Timeout = 1000;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       new_data;
  logic       pkt_valid;
  logic [7:0] pkt_cmd;
  logic [4:0] pkt_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       pkt_ack;
  logic       busy;
  logic       pkt_err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  uart_packet_parser #(
    .MAX_LEN(MaxLen),
    .TIMEOUT(Timeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .new_data (new_data),
    .pkt_valid(pkt_valid),
    .pkt_cmd  (pkt_cmd),
    .pkt_len  (pkt_len),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .pkt_ack  (pkt_ack),
    .busy     (busy),
    .pkt_err  (pkt_err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one byte for exactly one rising edge; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    data     = b;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
  endtask

  task automatic good_frame();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
  endtask

  initial begin
    rst      = 1'b1;
    data     = 8'h00;
    new_data = 1'b0;
    pkt_ack  = 1'b0;
    rd_addr  = 4'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(pkt_valid), 32'h0);
    chk("rst_err", 32'(pkt_err), 32'h0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_cmd", 32'(pkt_cmd), 32'h00);
    chk("rst_len", 32'(pkt_len), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Good frame
    send(8'hA5);
    chk("good_busy_cmd", 32'(busy), 32'h1);
    send(8'h10); send(8'h02); send(8'h33); send(8'h44);
    chk("good_no_valid_early", 32'(pkt_valid), 32'h0);
    send(8'h65);
    chk("good_valid", 32'(pkt_valid), 32'h1);
    chk("good_cmd", 32'(pkt_cmd), 32'h10);
    chk("good_len", 32'(pkt_len), 32'h2);
    chk("good_busy_hold", 32'(busy), 32'h0);
    chk("good_err", 32'(pkt_err), 32'h0);
    rd_addr = 4'd0; #1;
    chk("good_rd0", 32'(rd_data), 32'h33);
    rd_addr = 4'd1; #1;
    chk("good_rd1", 32'(rd_data), 32'h44);
    tick();
    chk("good_valid_held", 32'(pkt_valid), 32'h1);
    ack();
    chk("good_ack_valid", 32'(pkt_valid), 32'h0);
    chk("good_ack_busy", 32'(busy), 32'h0);

    // Zero length with leading junk
    send(8'h00); send(8'hFF);
    chk("junk_no_err", 32'(pkt_err), 32'h0);
    chk("junk_not_busy", 32'(busy), 32'h0);
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
    chk("zero_valid", 32'(pkt_valid), 32'h1);
    chk("zero_cmd", 32'(pkt_cmd), 32'h07);
    chk("zero_len", 32'(pkt_len), 32'h0);
    ack();

    // Bad checksum, then recovery
    send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h66);
    chk("badchk_err", 32'(pkt_err), 32'h1);
    chk("badchk_code", 32'(err_code), 32'h2);
    chk("badchk_valid", 32'(pkt_valid), 32'h0);
    chk("badchk_busy", 32'(busy), 32'h0);
    tick();
    chk("badchk_pulse_one", 32'(pkt_err), 32'h0);
    good_frame();
    chk("recover_valid", 32'(pkt_valid), 32'h1);
    chk("recover_code_held", 32'(err_code), 32'h2);
    ack();

    // Length violation and LEN = MAX_LEN boundary
    send(8'hA5); send(8'h01); send(8'h11);
    chk("len_err", 32'(pkt_err), 32'h1);
    chk("len_code", 32'(err_code), 32'h1);
    chk("len_busy", 32'(busy), 32'h0);
    send(8'hA5); send(8'h01); send(8'h10);
    chk("maxlen_err", 32'(pkt_err), 32'h0);
    chk("maxlen_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h11);
    chk("maxlen_valid", 32'(pkt_valid), 32'h1);
    chk("maxlen_len", 32'(pkt_len), 32'h10);
    rd_addr = 4'd15; #1;
    chk("maxlen_rd15", 32'(rd_data), 32'h0F);
    ack();

    // Timeout fires exactly TIMEOUT edges after the last byte
    send(8'hA5); send(8'h10);
    for (int i = 0; i < Timeout - 1; i++) tick();
    chk("to_not_yet", 32'(pkt_err), 32'h0);
    chk("to_busy_before", 32'(busy), 32'h1);
    tick();
    chk("to_err", 32'(pkt_err), 32'h1);
    chk("to_code", 32'(err_code), 32'h3);
    chk("to_busy_drop", 32'(busy), 32'h0);

    // Byte on the expiry cycle is accepted
    send(8'hA5); send(8'h10);
    for (int i = 0; i < Timeout - 1; i++) tick();
    send(8'h02);
    chk("to_rescue_err", 32'(pkt_err), 32'h0);
    chk("to_rescue_busy", 32'(busy), 32'h1);
    send(8'h33); send(8'h44); send(8'h65);
    chk("to_rescue_valid", 32'(pkt_valid), 32'h1);
    ack();

    // Overrun in HOLD
    good_frame();
    send(8'h55);
    chk("ovr_err", 32'(pkt_err), 32'h1);
    chk("ovr_code", 32'(err_code), 32'h0);
    chk("ovr_valid", 32'(pkt_valid), 32'h1);
    chk("ovr_cmd", 32'(pkt_cmd), 32'h10);
    chk("ovr_len", 32'(pkt_len), 32'h2);
    rd_addr = 4'd0; #1;
    chk("ovr_rd0", 32'(rd_data), 32'h33);

    // Ack together with sync byte enters CMD directly
    pkt_ack  = 1'b1;
    data     = 8'hA5;
    new_data = 1'b1;
    tick();
    pkt_ack  = 1'b0;
    new_data = 1'b0;
    chk("coll_busy", 32'(busy), 32'h1);
    chk("coll_valid", 32'(pkt_valid), 32'h0);
    chk("coll_err", 32'(pkt_err), 32'h0);
    send(8'h20); send(8'h01); send(8'hAB); send(8'h00);
    chk("coll_badchk_code", 32'(err_code), 32'h2);

    // Reset during PAYLOAD
    send(8'hA5); send(8'h30); send(8'h03); send(8'h01);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_valid", 32'(pkt_valid), 32'h0);
    chk("mid_rst_err", 32'(pkt_err), 32'h0);
    chk("mid_rst_code", 32'(err_code), 32'h0);
    chk("mid_rst_cmd", 32'(pkt_cmd), 32'h00);
    chk("mid_rst_len", 32'(pkt_len), 32'h0);
    send(8'h02);
    chk("post_rst_idle_byte", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_packet_parser.md
# uart_packet_parser

Consumes the byte stream produced by the UART receiver (one byte per `new_data` pulse) and assembles framed command packets. Frame format: sync `0xA5`, CMD, LEN, LEN payload bytes, CHK, where CHK = CMD ^ LEN ^ payload[0] ^ … ^ payload[LEN-1]. A validated packet is held for the command logic, which reads the payload through a random-access port and releases it with `pkt_ack`. Malformed, overlong, stalled or overrun frames are reported through an error pulse and a code.

## Interface
- `MAX_LEN`, default 16: maximum payload length in bytes; payload buffer depth.
- `TIMEOUT`, default 1000: maximum inter-byte gap, in clk cycles, tolerated inside a frame.
- Derived widths: `LEN_W = $clog2(MAX_LEN+1)`, `ADDR_W = $clog2(MAX_LEN)`, `TO_W = $clog2(TIMEOUT+1)`.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  8  received byte from the UART receiver; valid only while `new_data` = 1.
- `new_data`  in  1  one-cycle strobe, one per received byte.
- `pkt_valid`  out  1  a complete, checksum-correct packet is held.
- `pkt_cmd`  out  8  CMD byte of the held packet.
- `pkt_len`  out  LEN_W  LEN of the held packet.
- `rd_addr`  in  ADDR_W  payload read index.
- `rd_data`  out  8  payload byte at `rd_addr`; combinational read of the buffer.
- `pkt_ack`  in  1  consumer releases the held packet; honoured only while `pkt_valid` = 1.
- `busy`  out  1  a frame is in progress (states CMD, LEN, PAYLOAD, CHK).
- `pkt_err`  out  1  one-cycle error pulse.
- `err_code`  out  2  cause of the last error, held until the next error: 00 overrun, 01 length, 10 checksum, 11 timeout.

## Operation
- States: IDLE, CMD, LEN, PAYLOAD, CHK, HOLD. A byte is accepted on any rising edge where `new_data` = 1.
- IDLE: `0xA5` -> CMD. Any other byte is discarded silently, with no error.
- CMD: store `pkt_cmd`, init running XOR = byte -> LEN.
- LEN: if byte > MAX_LEN -> error 01, go to IDLE. Otherwise store `pkt_len`, XOR it in, clear payload index; LEN = 0 -> CHK, else -> PAYLOAD.
- PAYLOAD: write byte to buffer[index], XOR it in, increment index; when index reaches LEN-1 on this byte -> CHK.
- CHK: byte == running XOR -> HOLD. Mismatch -> error 10, go to IDLE.
- HOLD: `pkt_valid` = 1; `pkt_cmd`, `pkt_len` and buffer are frozen.
  - `pkt_ack` -> IDLE.
  - A byte arriving without `pkt_ack` in the same cycle is dropped and raises error 00; the parser stays in HOLD.
  - `pkt_ack` and `new_data` in the same cycle: the ack wins, and the byte is evaluated as an IDLE byte (`0xA5` enters CMD directly).
- Timeout:
  - Counter clears on every accepted byte and counts while `busy` = 1.
  - With no byte, reaching TIMEOUT -> error 11, go to IDLE.
  - A byte arriving on the expiry cycle is accepted and the timeout does not fire.
- Reads of `rd_addr` >= `pkt_len`, and reads outside HOLD, return stale buffer contents; they are legal and have no side effects.
- `pkt_ack` outside HOLD is ignored.

## Timing
- Reset values: `pkt_valid` 0, `pkt_err` 0, `err_code` 00, `pkt_cmd` 0x00, `pkt_len` 0, `busy` 0; state IDLE; timeout counter 0. Buffer contents are not cleared.
- Reset asserted mid-frame or in HOLD: the next cycle is IDLE with all of the above values; the partial frame is lost and no error is reported.
- `pkt_valid` rises the cycle after the edge that accepts a good CHK byte.
- `pkt_valid` falls the cycle after the edge that samples `pkt_ack`.
- `pkt_err` is high for exactly the one cycle after the offending edge; `err_code` updates on the same edge.
- `busy` is registered and follows the state with the same latency.
- `rd_data` is valid in the same cycle as `rd_addr`, with zero latency.
- Throughput: one byte per cycle is sustained; back-to-back `new_data` pulses are legal in every state.

## Test plan
- Good frame: bytes A5 10 02 33 44 65 -> `pkt_valid` = 1 one cycle after the CHK byte; `pkt_cmd` = 0x10, `pkt_len` = 2; `rd_addr` 0 -> 0x33, `rd_addr` 1 -> 0x44; `pkt_ack` -> `pkt_valid` = 0 the next cycle, `busy` = 0.
- Zero length plus junk: bytes 00 FF A5 07 00 07 -> junk ignored with no `pkt_err`; `pkt_valid` = 1 with `pkt_cmd` = 0x07, `pkt_len` = 0.
- Bad checksum: bytes A5 10 02 33 44 66 -> one-cycle `pkt_err`, `err_code` = 10, `pkt_valid` stays 0, state returns to IDLE. Then send A5 10 02 33 44 65 -> valid packet.
- Length violation: bytes A5 01 11 (17 > MAX_LEN) -> `pkt_err` with `err_code` = 01. Edge case: LEN = 0x10 is accepted.
- Timeout: A5 10, then idle -> `pkt_err` with `err_code` = 11 exactly TIMEOUT cycles after the 0x10 edge, and `busy` drops. Repeat with a byte on cycle TIMEOUT -> no error.
- Overrun, ack collision and reset:
  - In HOLD, send 0x55 without ack -> `err_code` = 00, packet unchanged.
  - Send `pkt_ack` together with 0xA5 -> `busy` = 1 on the next cycle.
  - Assert `rst` during PAYLOAD -> all outputs at reset values on the next cycle.
